// File: rtl/car_sensor_driver.sv
// Sensor-pattern generator: emits the outer/inner (a/b) waveform of 1..31 car passes
// in one direction per accepted request, with a ready/busy handshake and a done pulse.
module car_sensor_driver #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dir,
    input  logic [4:0] num_cars,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       a,
    output logic       b,
    output logic [4:0] cars_sent
);

    localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StPh1, StPh2, StPh3, StPh4} state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       dir_q, dir_d;
    logic [4:0] num_q, num_d;
    logic [4:0] cars_q, cars_d;
    logic       zero_pend_q, zero_pend_d;
    logic       a_q, a_d, b_q, b_d;
    logic       ready_q, ready_d;
    logic       done_q, done_d;
    logic       burst_end;
    logic       phase_done;
    logic [5:0] cars_inc;

    assign phase_done = (hold_q == 8'd0);
    assign cars_inc   = {1'b0, cars_q} + 6'd1;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        dir_d       = dir_q;
        num_d       = num_q;
        cars_d      = cars_q;
        zero_pend_d = 1'b0;
        burst_end   = 1'b0;

        if (state_q != StIdle) begin
            hold_d = phase_done ? HoldLoad : hold_q - 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cars_d = '0;
                    if (num_cars != 5'd0) begin
                        state_d = StPh1;
                        hold_d  = HoldLoad;
                        dir_d   = dir;
                        num_d   = num_cars;
                    end else begin
                        // Empty request: acknowledge one cycle later, no sensor activity.
                        zero_pend_d = 1'b1;
                    end
                end
            end
            StPh1: if (phase_done) state_d = StPh2;
            StPh2: if (phase_done) state_d = StPh3;
            StPh3: if (phase_done) state_d = StPh4;
            StPh4: begin
                if (phase_done) begin
                    cars_d = cars_inc[4:0];
                    if (cars_inc < {1'b0, num_q}) begin
                        state_d = StPh1;
                    end else begin
                        state_d   = StIdle;
                        burst_end = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they change on the accepting edge.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        unique case (state_d)
            StPh1: begin
                a_d = ~dir_d;
                b_d = dir_d;
            end
            StPh2: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            StPh3: begin
                a_d = dir_d;
                b_d = ~dir_d;
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
        ready_d = (state_d == StIdle);
        done_d  = burst_end | zero_pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            dir_q       <= 1'b0;
            num_q       <= '0;
            cars_q      <= '0;
            zero_pend_q <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            dir_q       <= dir_d;
            num_q       <= num_d;
            cars_q      <= cars_d;
            zero_pend_q <= zero_pend_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign ready     = ready_q;
    assign busy      = ~ready_q;
    assign done      = done_q;
    assign cars_sent = cars_q;

endmodule

// File: tb/tb_car_sensor_driver.sv
// Directed self-checking bench for car_sensor_driver at HOLD_CYCLES=2 and HOLD_CYCLES=1.
module tb_car_sensor_driver;

    logic       clk;
    logic       reset;
    logic       start, dir;
    logic [4:0] num_cars;
    logic       ready, busy, done, a, b;
    logic [4:0] cars_sent;

    logic       start1, dir1;
    logic [4:0] num_cars1;
    logic       ready1, busy1, done1, a1, b1;
    logic [4:0] cars_sent1;

    int n_checks = 0;
    int n_errors = 0;

    car_sensor_driver #(.HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dir       (dir),
        .num_cars  (num_cars),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .a         (a),
        .b         (b),
        .cars_sent (cars_sent)
    );

    car_sensor_driver #(.HOLD_CYCLES(1)) dut1 (
        .clk       (clk),
        .reset     (reset),
        .start     (start1),
        .dir       (dir1),
        .num_cars  (num_cars1),
        .ready     (ready1),
        .busy      (busy1),
        .done      (done1),
        .a         (a1),
        .b         (b1),
        .cars_sent (cars_sent1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] exp_ab(input logic d, input int p);
        case (p)
            0:       return d ? 2'b01 : 2'b10;
            1:       return 2'b11;
            2:       return d ? 2'b10 : 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Called #1 after the accepting edge t0 of the HOLD_CYCLES=2 instance.
    task automatic expect_burst(input logic d, input int n, input bit disturb);
        for (int c = 0; c < n; c++) begin
            check("cars_mid", 32'(cars_sent), 32'(c));
            for (int p = 0; p < 4; p++) begin
                for (int r = 0; r < 2; r++) begin
                    check("ab", 32'({a, b}), 32'(exp_ab(d, p)));
                    check("busy", 32'(busy), 32'd1);
                    if (disturb) begin
                        start    = 1'($urandom);
                        dir      = ~d;
                        num_cars = 5'($urandom);
                    end
                    tick();
                end
            end
        end
        start = 1'b0;
        check("done", 32'(done), 32'd1);
        check("ready_end", 32'(ready), 32'd1);
        check("cars_end", 32'(cars_sent), 32'(n));
        check("ab_idle", 32'({a, b}), 32'd0);
        tick();
        check("done_drop", 32'(done), 32'd0);
    endtask

    // Illegal single-step changes on either sensor pair while out of reset.
    logic [1:0] prev_ab, prev_ab1;
    bit         mon_valid = 1'b0;
    always @(negedge clk) begin
        if (reset && mon_valid) begin
            check("step", 32'((prev_ab ^ {a, b}) == 2'b11), 32'd0);
            check("step1", 32'((prev_ab1 ^ {a1, b1}) == 2'b11), 32'd0);
        end
        prev_ab   = {a, b};
        prev_ab1  = {a1, b1};
        mon_valid = reset;
    end

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        dir       = 1'b0;
        num_cars  = 5'd0;
        start1    = 1'b0;
        dir1      = 1'b0;
        num_cars1 = 5'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_ab", 32'({a, b}), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cars", 32'(cars_sent), 32'd0);
        reset = 1'b1;

        // One car entering.
        start = 1'b1; dir = 1'b0; num_cars = 5'd1;
        tick();
        start = 1'b0;
        check("t0_ready", 32'(ready), 32'd0);
        expect_burst(1'b0, 1, 1'b0);

        // Empty request.
        start = 1'b1; num_cars = 5'd0;
        tick();
        start = 1'b0;
        check("z_done_t0", 32'(done), 32'd0);
        check("z_ready_t0", 32'(ready), 32'd1);
        check("z_cars_t0", 32'(cars_sent), 32'd0);
        check("z_ab_t0", 32'({a, b}), 32'd0);
        tick();
        check("z_done_t1", 32'(done), 32'd1);
        check("z_ready_t1", 32'(ready), 32'd1);
        check("z_ab_t1", 32'({a, b}), 32'd0);
        tick();
        check("z_done_t2", 32'(done), 32'd0);

        // Five cars exiting.
        start = 1'b1; dir = 1'b1; num_cars = 5'd5;
        tick();
        start = 1'b0;
        expect_burst(1'b1, 5, 1'b0);

        // Three entering cars with inputs disturbed throughout.
        start = 1'b1; dir = 1'b0; num_cars = 5'd3;
        tick();
        expect_burst(1'b0, 3, 1'b1);
        dir = 1'b0; num_cars = 5'd0;

        // Reset during PH2 of the second car.
        start = 1'b1; dir = 1'b0; num_cars = 5'd3;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("pre_rst_ab", 32'({a, b}), 32'b11);
        check("pre_rst_cars", 32'(cars_sent), 32'd1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_ab", 32'({a, b}), 32'd0);
        check("mid_rst_cars", 32'(cars_sent), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        check("rst_hold_done", 32'(done), 32'd0);
        reset = 1'b1;
        start = 1'b1; dir = 1'b0; num_cars = 5'd1;
        tick();
        start = 1'b0;
        expect_burst(1'b0, 1, 1'b0);

        // HOLD_CYCLES=1 with start held high across done.
        start1 = 1'b1; dir1 = 1'b0; num_cars1 = 5'd2;
        tick();
        for (int i = 0; i < 8; i++) begin
            check("h1_ab_enter", 32'({a1, b1}), 32'(exp_ab(1'b0, i % 4)));
            tick();
        end
        check("h1_done1", 32'(done1), 32'd1);
        check("h1_ready1", 32'(ready1), 32'd1);
        check("h1_cars1", 32'(cars_sent1), 32'd2);
        dir1 = 1'b1; num_cars1 = 5'd1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("h1_ab_exit", 32'({a1, b1}), 32'(exp_ab(1'b1, i)));
            check("h1_busy", 32'(busy1), 32'd1);
            tick();
        end
        start1 = 1'b0;
        check("h1_done2", 32'(done1), 32'd1);
        check("h1_cars2", 32'(cars_sent1), 32'd1);
        tick();
        check("h1_done_drop", 32'(done1), 32'd0);
        check("h1_idle", 32'(ready1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
